// File: rtl/persp_pkg.sv
// persp_pkg: shared state encoding, Q16.16 constants and saturation helper for perspective_divide.
package persp_pkg;
    typedef enum logic [2:0] {S_IDLE, S_DIV, S_MUL, S_MAP, S_OUT} state_e;
    localparam int Q_FRAC = 16;
    localparam logic [31:0] FX_ONE = 32'h0001_0000;
    localparam logic [31:0] W_MIN = 32'h0000_0002;
    function automatic logic signed [31:0] sat32(input logic signed [63:0] v);
        return (v > 64'sh0000_0000_7FFF_FFFF) ? 32'sh7FFF_FFFF :
               (v < $signed(64'hFFFF_FFFF_8000_0000)) ? $signed(32'h8000_0000) : v[31:0];
    endfunction
endpackage

// File: rtl/recip_div.sv
// recip_div: restoring divider producing 2^32 / d_i in exactly 32 cycles after start_i.
module recip_div (
    input  logic        clk_in,
    input  logic        rst_in_n,
    input  logic        start_i,
    input  logic [31:0] d_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [32:0] q_o
);
    logic [31:0] d_q, rem_q, rem_d;
    logic [32:0] q_q, rem_sh;
    logic [4:0]  cnt_q;
    logic        busy_q, ge;
    always_comb begin
        rem_sh = {rem_q, 1'b0};
        ge     = rem_sh >= {1'b0, d_q};
        rem_d  = ge ? 32'(rem_sh - {1'b0, d_q}) : rem_sh[31:0];
    end
    // The dividend's leading 1 is resolved at start, leaving 32 zero bits to shift in
    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            d_q    <= '0;
            rem_q  <= '0;
            q_q    <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (start_i) begin
            d_q    <= d_i;
            rem_q  <= (d_i == 32'd1) ? 32'd0 : 32'd1;
            q_q    <= {32'd0, d_i == 32'd1};
            cnt_q  <= '0;
            busy_q <= 1'b1;
        end else if (busy_q) begin
            rem_q  <= rem_d;
            q_q    <= {q_q[31:0], ge};
            cnt_q  <= cnt_q + 5'd1;
            busy_q <= cnt_q != 5'd31;
        end
    end
    assign busy_o = busy_q;
    assign done_o = busy_q && cnt_q == 5'd31;
    assign q_o    = q_q;
endmodule

// File: rtl/perspective_divide.sv
// perspective_divide: divides a Q16.16 clip-space vector by w and maps it to viewport pixels.
// Define PERSP_DROP_CNT_EN to count inputs dropped while the block is busy.
module perspective_divide
    import persp_pkg::*;
#(
    parameter int WIDTH   = 540,
    parameter int HEIGHT  = 540,
    parameter int COORD_W = 10
) (
    input  logic                clk_in,
    input  logic                rst_in_n,
    input  logic                valid_in,
    input  logic [3:0][31:0]    vec_in,
    output logic                ready_out,
    output logic                valid_out,
    input  logic                ready_in,
    output logic [COORD_W-1:0]  x_pix,
    output logic [COORD_W-1:0]  y_pix,
    output logic [15:0]         depth,
    output logic                clipped,
    output logic [15:0]         drop_count
);
    localparam logic signed [47:0] HW = 48'(WIDTH / 2);
    localparam logic signed [47:0] HH = 48'(HEIGHT / 2);
    localparam logic signed [31:0] ONE = FX_ONE;

    function automatic logic signed [31:0] ndc(input logic [31:0] c, input logic signed [63:0] r);
        return sat32(($signed({{32{c[31]}}, c}) * r) >>> Q_FRAC);
    endfunction
    function automatic logic signed [47:0] scale(input logic signed [31:0] v, input logic signed [47:0] k);
        return ($signed({{16{v[31]}}, v}) * k) >>> Q_FRAC;
    endfunction
    function automatic logic [COORD_W-1:0] clampc(input logic signed [47:0] v, input int mx);
        return (v < 0) ? '0 : (v > 48'(mx)) ? COORD_W'(mx) : v[COORD_W-1:0];
    endfunction

    state_e               state_q, state_d;
    logic [2:0][31:0]     vec_q;
    logic                 inv_q, clip_q, clip_d, accept, div_busy, div_done;
    logic signed [31:0]   xn_q, yn_q, zn_q, xn_d, yn_d, zn_d;
    logic [COORD_W-1:0]   x_q, y_q, x_d, y_d;
    logic [15:0]          dep_q, dep_d;
    logic [31:0]          w_abs;
    logic [32:0]          quo;
    logic signed [63:0]   recip_s;
    logic signed [47:0]   xv, yv, zv;

    assign accept = state_q == S_IDLE && valid_in;
    assign w_abs  = vec_in[3][31] ? -vec_in[3] : vec_in[3];

    recip_div u_div (
        .clk_in  (clk_in),
        .rst_in_n(rst_in_n),
        .start_i (accept),
        .d_i     (w_abs),
        .busy_o  (div_busy),
        .done_o  (div_done),
        .q_o     (quo)
    );

    always_comb begin
        state_d = (accept) ? S_DIV :
                  (state_q == S_DIV && div_done) ? S_MUL :
                  (state_q == S_MUL) ? S_MAP :
                  (state_q == S_MAP) ? S_OUT :
                  (state_q == S_OUT && ready_in) ? S_IDLE : state_q;
        recip_s = {31'd0, inv_q ? 33'd0 : quo};
        xn_d    = ndc(vec_q[0], recip_s);
        yn_d    = ndc(vec_q[1], recip_s);
        zn_d    = ndc(vec_q[2], recip_s);
        xv      = HW + scale(xn_q, HW);
        yv      = HH - scale(yn_q, HH);
        zv      = ($signed({{16{zn_q[31]}}, zn_q}) + 48'sh1_0000) >>> 1;
        x_d     = clampc(xv, WIDTH - 1);
        y_d     = clampc(yv, HEIGHT - 1);
        dep_d   = (zv < 0) ? 16'h0000 : (zv > 48'sh0_FFFF) ? 16'hFFFF : zv[15:0];
        clip_d  = inv_q || xn_q > ONE || xn_q < -ONE || yn_q > ONE || yn_q < -ONE;
    end

    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            state_q <= S_IDLE;
            vec_q   <= '0;
            inv_q   <= 1'b0;
            xn_q    <= '0;
            yn_q    <= '0;
            zn_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            dep_q   <= '0;
            clip_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                vec_q <= vec_in[2:0];
                inv_q <= $signed(vec_in[3]) < $signed(W_MIN);
            end
            if (state_q == S_MUL) begin
                xn_q <= xn_d;
                yn_q <= yn_d;
                zn_q <= zn_d;
            end
            if (state_q == S_MAP) begin
                x_q    <= x_d;
                y_q    <= y_d;
                dep_q  <= dep_d;
                clip_q <= clip_d;
            end
        end
    end

    assert property (@(posedge clk_in) disable iff (!rst_in_n) state_q == S_DIV |-> div_busy);

    assign ready_out = state_q == S_IDLE;
    assign valid_out = state_q == S_OUT;
    assign x_pix     = x_q;
    assign y_pix     = y_q;
    assign depth     = dep_q;
    assign clipped   = clip_q;

`ifdef PERSP_DROP_CNT_EN
    logic [15:0] drop_q;
    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n)
            drop_q <= '0;
        else if (valid_in && !ready_out && drop_q != 16'hFFFF)
            drop_q <= drop_q + 16'd1;
    end
    assign drop_count = drop_q;
`else
    assign drop_count = '0;
`endif
endmodule
